lzx_coin_tx: RTL

Coin-acceptor front end that drives the 2-bit coin code bus consumed by the vending-machine controller (lzx_VM).
- Synchronises and debounces two raw coin-sensor lines.
- Queues detected coins in a small FIFO.
- Transmits each coin as a single-cycle code on In, followed by a mandatory idle gap.
- Bus encoding: 2'b00 none, 2'b01 = 0.5 yuan, 2'b10 = 1 yuan; 2'b11 is never driven.

---
 rtl/lzx_coin_pkg.sv | 9 +
 rtl/lzx_coin_debounce.sv | 31 +++
 rtl/lzx_coin_tx.sv | 89 ++++++++
 3 files changed

// File: rtl/lzx_coin_pkg.sv
// lzx_coin_pkg: coin bus codes, TX FSM states and credit values shared with lzx_VM.
package lzx_coin_pkg;
    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_HALF = 2'b01;
    localparam logic [1:0] COIN_ONE  = 2'b10;
    localparam logic [7:0] HALF_UNITS = 8'd1;
    localparam logic [7:0] ONE_UNITS  = 8'd2;
    typedef enum logic [1:0] {IDLE, SEND, GAP} tx_state_t;
endpackage

// File: rtl/lzx_coin_debounce.sv
// lzx_coin_debounce: 2-FF synchroniser, stability counter and one-cycle pulse on debounced rise.
module lzx_coin_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic rise
);
    logic s1, s2, level;
    logic [7:0] cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            cnt   <= '0;
            rise  <= 1'b0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level) cnt <= '0;
            else if (cnt == 8'(DEB_CYCLES - 1)) begin
                level <= s2;
                cnt   <= '0;
                rise  <= s2;
            end else cnt <= cnt + 8'd1;
        end
    end
endmodule

// File: rtl/lzx_coin_tx.sv
// lzx_coin_tx: debounced coin sensors -> FIFO -> single-cycle codes on In with idle gap.
// Optional LZX_COIN_TX_TOTAL_EN adds clr_total/credit_total (0.5-yuan units, saturating).
module lzx_coin_tx
    import lzx_coin_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter int DEPTH      = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sens_half,
    input  logic                         sens_one,
    input  logic                         hold,
    output logic [1:0]                   In,
    output logic                         coin_reject,
    output logic [$clog2(DEPTH+1)-1:0]   pending
`ifdef LZX_COIN_TX_TOTAL_EN
    ,
    input  logic                         clr_total,
    output logic [7:0]                   credit_total
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic half_rise, one_rise, half_pend, push_req, push, pop, full, gap_last;
    logic [1:0] mem [DEPTH];
    logic [1:0] in_d;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [3:0] gap_cnt;
    tx_state_t state, state_d;

    lzx_coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_half (
        .clk(clk), .rst_n(rst_n), .raw(sens_half), .rise(half_rise)
    );
    lzx_coin_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_one (
        .clk(clk), .rst_n(rst_n), .raw(sens_one), .rise(one_rise)
    );

    // 1-yuan wins a same-cycle tie; the half coin waits one edge in half_pend
    assign push_req = one_rise | half_rise | half_pend;
    assign full     = pending == CW'(DEPTH);
    assign push     = push_req && !full;

    always_comb begin
        gap_last = gap_cnt == 4'(GAP_CYCLES - 1);
        pop      = pending != '0 && !hold && (state == IDLE || (state == GAP && gap_last));
        in_d     = pop ? mem[rd_ptr] : COIN_NONE;
        state_d  = pop ? SEND : state == SEND ? GAP : (state == GAP && gap_last) ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= one_rise ? COIN_ONE : COIN_HALF;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            pending     <= '0;
            half_pend   <= 1'b0;
            coin_reject <= 1'b0;
            state       <= IDLE;
            gap_cnt     <= '0;
            In          <= COIN_NONE;
        end else begin
            half_pend   <= one_rise & half_rise;
            coin_reject <= push_req & full;
            wr_ptr      <= push ? wr_ptr + AW'(1) : wr_ptr;
            rd_ptr      <= pop ? rd_ptr + AW'(1) : rd_ptr;
            pending     <= pending + CW'(push) - CW'(pop);
            state       <= state_d;
            gap_cnt     <= state == GAP ? gap_cnt + 4'd1 : '0;
            In          <= in_d;
        end
    end

`ifdef LZX_COIN_TX_TOTAL_EN
    logic [7:0] add;
    logic [8:0] sum;
    assign add = In == COIN_ONE ? ONE_UNITS : HALF_UNITS;
    assign sum = {1'b0, credit_total} + {1'b0, add};
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) credit_total <= '0;
        else if (clr_total) credit_total <= '0;
        else if (state == SEND && In != COIN_NONE) credit_total <= sum[8] ? 8'hFF : sum[7:0];
    end
`endif
endmodule
